// File: rtl/result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : result_serializer
// Brief   : Queues wide result words in a FIFO and streams them out bytewise
//           to a UART transmitter using a start/busy handshake.
// Revision: 1.0 - initial release
// ============================================================================
module result_serializer #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              w_en,
    output logic              full,
    output logic              empty,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              idle,
    output logic              overflow,
    output logic [15:0]       sent_words
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_nb = DATA_W / 8;
    localparam int c_iw = (c_nb > 1) ? $clog2(c_nb) : 1;

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_send = 2'd1;
    localparam logic [1:0] c_s_hold = 2'd2;
    localparam logic [1:0] c_s_wait = 2'd3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic [c_aw:0]     w_count_next;
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [c_iw-1:0]   r_byte_idx;
    logic              w_pop;
    logic              w_push;
    logic              w_last;
    logic [DATA_W-1:0] w_head;
    logic [7:0]        w_head_byte;
    logic [DATA_W-1:0] w_head_rest;
    logic [7:0]        w_cur_byte;
    logic [DATA_W-1:0] w_cur_rest;

    assign w_head = r_mem[r_rd_ptr];
    assign w_pop  = (r_state == c_s_idle) && !empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    assign w_push = w_en && (!full || w_pop);
    assign w_last = (r_byte_idx == c_iw'(c_nb - 1));

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_head_byte = w_head[7:0];
            assign w_head_rest = w_head >> 8;
            assign w_cur_byte  = r_shift[7:0];
            assign w_cur_rest  = r_shift >> 8;
        end else begin : g_msb_first
            assign w_head_byte = w_head[DATA_W-1 -: 8];
            assign w_head_rest = w_head << 8;
            assign w_cur_byte  = r_shift[DATA_W-1 -: 8];
            assign w_cur_rest  = r_shift << 8;
        end
    endgenerate

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (c_aw+1)'(1);
            2'b01:   w_count_next = r_count - (c_aw+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= w_count_next;
            full    <= (w_count_next == (c_aw+1)'(DEPTH));
            empty   <= (w_count_next == '0);
            if (w_en && full && !w_pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_idle: if (!empty)  w_state_next = c_s_send;
            c_s_send: if (!tx_busy) w_state_next = c_s_hold;
            c_s_hold: w_state_next = c_s_wait;
            c_s_wait: if (!tx_busy) w_state_next = w_last ? c_s_idle : c_s_send;
            default:  w_state_next = c_s_idle;
        endcase
    end

    always_comb begin
        tx_start = (r_state == c_s_send) && !tx_busy;
        idle     = empty && (r_state == c_s_idle);
    end

    // tx_data is loaded only when entering SEND, so it stays stable through HOLD and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
            tx_data    <= 8'h00;
            sent_words <= 16'h0000;
        end else begin
            if (w_pop) begin
                tx_data    <= w_head_byte;
                r_shift    <= w_head_rest;
                r_byte_idx <= '0;
            end else if ((r_state == c_s_wait) && !tx_busy) begin
                if (w_last) begin
                    sent_words <= sent_words + 16'd1;
                end else begin
                    tx_data    <= w_cur_byte;
                    r_shift    <= w_cur_rest;
                    r_byte_idx <= r_byte_idx + c_iw'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_result_serializer
// Brief   : Directed testbench for result_serializer with a UART transmitter model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_result_serializer;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
    logic        w_en;
    logic        tx_busy;
    logic        use_m;

    logic        full, empty, tx_start, idle, overflow;
    logic [7:0]  tx_data;
    logic [15:0] sent_words;
    logic        full_m, empty_m, tx_start_m, idle_m, overflow_m;
    logic [7:0]  tx_data_m;
    logic [15:0] sent_m;

    int n_cmp  = 0;
    int n_fail = 0;

    // transmitter model state
    int       busy_len  = 10;
    logic     late      = 1'b0;
    logic     hold_busy = 1'b0;
    int       bcnt      = 0;
    logic     pend      = 1'b0;
    logic     start_q   = 1'b0;
    logic     prev_start = 1'b0;
    int       consec    = 0;
    int       busy_viol = 0;
    logic [7:0] log_q[$];

    wire        sel_start = use_m ? tx_start_m : tx_start;
    wire [7:0]  sel_data  = use_m ? tx_data_m  : tx_data;
    wire [15:0] sel_sent  = use_m ? sent_m     : sent_words;

    result_serializer #(.DATA_W(64), .DEPTH(4), .LSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en && !use_m),
        .full(full), .empty(empty), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .idle(idle), .overflow(overflow), .sent_words(sent_words)
    );

    result_serializer #(.DATA_W(64), .DEPTH(4), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en && use_m),
        .full(full_m), .empty(empty_m), .tx_data(tx_data_m), .tx_start(tx_start_m),
        .tx_busy(tx_busy), .idle(idle_m), .overflow(overflow_m), .sent_words(sent_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && sel_start) begin
            log_q.push_back(sel_data);
            if (tx_busy)    busy_viol++;
            if (prev_start) consec++;
        end
        prev_start = !rst && sel_start;
        start_q    = !rst && sel_start;
    end

    // busy rises after the start edge (or one cycle later in late mode) and lasts busy_len cycles
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bcnt = 0; pend = 1'b0; tx_busy = 1'b0;
        end else if (hold_busy) begin
            tx_busy = 1'b1;
        end else if (start_q && !late) begin
            bcnt = busy_len; tx_busy = 1'b1;
        end else if (start_q && late) begin
            pend = 1'b1;
        end else if (pend) begin
            pend = 1'b0; bcnt = busy_len; tx_busy = 1'b1;
        end else if (bcnt > 1) begin
            bcnt--;
        end else begin
            bcnt = 0; tx_busy = 1'b0;
        end
    end

    function automatic logic [63:0] mk(input int i);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((i << 4) | k);
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic write_burst(input int first, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            data_in = mk(first + i); w_en = 1'b1;
            @(negedge clk);
        end
        w_en = 1'b0;
    endtask

    task automatic wait_sent(input logic [15:0] target, input string name);
        int cyc = 0;
        while (sel_sent !== target && cyc < 3000) begin
            @(negedge clk); cyc++;
        end
        n_cmp++;
        if (sel_sent !== target) begin
            n_fail++;
            $display("FAIL %s timeout: sent_words=%0d want %0d", name, sel_sent, target);
        end
    endtask

    task automatic check_words(input int base, input int first, input int nw, input string name);
        n_cmp++;
        if (log_q.size() - base !== nw * 8) begin
            n_fail++;
            $display("FAIL %s pulses: got %0d want %0d", name, log_q.size() - base, nw * 8);
        end else begin
            for (int j = 0; j < nw * 8; j++) begin
                n_cmp++;
                if (log_q[base + j] !== 8'(((first + j / 8) << 4) | (j % 8))) begin
                    n_fail++;
                    $display("FAIL %s byte %0d: got %h want %h", name, j, log_q[base + j],
                             8'(((first + j / 8) << 4) | (j % 8)));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp += 7;
        if (full !== 1'b0)        begin n_fail++; $display("FAIL rst full: got %b want 0", full); end
        if (empty !== 1'b1)       begin n_fail++; $display("FAIL rst empty: got %b want 1", empty); end
        if (idle !== 1'b1)        begin n_fail++; $display("FAIL rst idle: got %b want 1", idle); end
        if (tx_start !== 1'b0)    begin n_fail++; $display("FAIL rst tx_start: got %b want 0", tx_start); end
        if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL rst tx_data: got %h want 00", tx_data); end
        if (overflow !== 1'b0)    begin n_fail++; $display("FAIL rst overflow: got %b want 0", overflow); end
        if (sent_words !== 16'd0) begin n_fail++; $display("FAIL rst sent_words: got %0d want 0", sent_words); end
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single(input logic msb);
        logic [7:0] exp_b [8];
        int base;
        use_m = msb; busy_len = 10;
        base = log_q.size();
        @(negedge clk);
        data_in = 64'h0807060504030201; w_en = 1'b1;
        @(negedge clk); w_en = 1'b0;
        if (!msb) begin
            n_cmp += 2;
            if (empty !== 1'b0) begin n_fail++; $display("FAIL lat empty: got %b want 0", empty); end
            if (idle !== 1'b0)  begin n_fail++; $display("FAIL lat idle: got %b want 0", idle); end
            @(negedge clk);
            n_cmp += 2;
            if (tx_start !== 1'b1) begin n_fail++; $display("FAIL lat tx_start: got %b want 1", tx_start); end
            if (tx_data !== 8'h01) begin n_fail++; $display("FAIL lat tx_data: got %h want 01", tx_data); end
        end
        wait_sent(16'd1, msb ? "msb_done" : "lsb_done");
        for (int k = 0; k < 8; k++) exp_b[k] = msb ? 8'(8 - k) : 8'(k + 1);
        n_cmp++;
        if (log_q.size() - base !== 8) begin
            n_fail++; $display("FAIL single pulses: got %0d want 8", log_q.size() - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (log_q[base + k] !== exp_b[k]) begin
                    n_fail++; $display("FAIL single byte %0d: got %h want %h", k, log_q[base + k], exp_b[k]);
                end
            end
        end
        n_cmp++;
        if ((msb ? idle_m : idle) !== 1'b1) begin n_fail++; $display("FAIL single idle: got 0 want 1"); end
        use_m = 1'b0;
    endtask

    task automatic fill_held(input string name);
        hold_busy = 1'b1;
        @(negedge clk); @(negedge clk);
        write_burst(1, 5);
        n_cmp += 2;
        if (full !== 1'b1)     begin n_fail++; $display("FAIL %s full: got %b want 1", name, full); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL %s ovf: got %b want 0", name, overflow); end
    endtask

    task automatic test_overflow();
        int base;
        do_reset(); busy_len = 2;
        base = log_q.size();
        fill_held("ovf5");
        write_burst(6, 1);
        n_cmp += 2;
        if (full !== 1'b1)     begin n_fail++; $display("FAIL ovf6 full: got %b want 1", full); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf6 ovf: got %b want 1", overflow); end
        hold_busy = 1'b0;
        wait_sent(16'd5, "ovf_done");
        check_words(base, 1, 5, "ovf");
        n_cmp++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf sticky: got %b want 1", overflow); end
    endtask

    task automatic test_simul();
        int base;
        do_reset(); busy_len = 2;
        base = log_q.size();
        fill_held("sim");
        hold_busy = 1'b0;
        wait_sent(16'd1, "sim_first");
        data_in = mk(6); w_en = 1'b1;
        @(negedge clk); w_en = 1'b0;
        n_cmp += 2;
        if (full !== 1'b1)     begin n_fail++; $display("FAIL sim full: got %b want 1", full); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL sim ovf: got %b want 0", overflow); end
        wait_sent(16'd6, "sim_done");
        check_words(base, 1, 6, "sim");
    endtask

    task automatic test_reset_mid();
        int base;
        int cyc = 0;
        do_reset(); busy_len = 4;
        base = log_q.size();
        @(negedge clk); data_in = 64'hAABBCCDDEEFF1122; w_en = 1'b1;
        @(negedge clk); w_en = 1'b0;
        while (log_q.size() < base + 3 && cyc < 500) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (log_q.size() != base + 3) begin
            n_fail++; $display("FAIL mid three bytes: got %0d want 3", log_q.size() - base);
        end else if ({log_q[base], log_q[base+1], log_q[base+2]} !== 24'h2211FF) begin
            n_fail++; $display("FAIL mid first bytes: got %h%h%h want 2211ff",
                               log_q[base], log_q[base+1], log_q[base+2]);
        end
        @(posedge clk); #3 rst = 1'b1;
        #1;
        n_cmp += 3;
        if (tx_start !== 1'b0)    begin n_fail++; $display("FAIL mid tx_start: got %b want 0", tx_start); end
        if (empty !== 1'b1)       begin n_fail++; $display("FAIL mid empty: got %b want 1", empty); end
        if (sent_words !== 16'd0) begin n_fail++; $display("FAIL mid sent: got %0d want 0", sent_words); end
        @(posedge clk); @(negedge clk); rst = 1'b0;
        base = log_q.size();
        @(negedge clk); data_in = 64'h1; w_en = 1'b1;
        @(negedge clk); w_en = 1'b0;
        wait_sent(16'd1, "mid_after");
        n_cmp++;
        if (log_q.size() - base !== 8) begin
            n_fail++; $display("FAIL mid after pulses: got %0d want 8", log_q.size() - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (log_q[base + k] !== ((k == 0) ? 8'h01 : 8'h00)) begin
                    n_fail++; $display("FAIL mid after byte %0d: got %h want %h", k, log_q[base + k],
                                       (k == 0) ? 8'h01 : 8'h00);
                end
            end
        end
    endtask

    task automatic test_busy_late();
        int base;
        do_reset(); late = 1'b1; busy_len = 3;
        base = log_q.size();
        write_burst(1, 2);
        wait_sent(16'd2, "late_done");
        check_words(base, 1, 2, "late");
        late = 1'b0;
        n_cmp += 2;
        if (consec !== 0)    begin n_fail++; $display("FAIL back_to_back_start: got %0d want 0", consec); end
        if (busy_viol !== 0) begin n_fail++; $display("FAIL start_while_busy: got %0d want 0", busy_viol); end
    endtask

    initial begin
        rst = 1'b0; data_in = '0; w_en = 1'b0; tx_busy = 1'b0; use_m = 1'b0;
        @(negedge clk);
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_overflow();
        test_simul();
        test_reset_mid();
        test_busy_late();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_serializer.md
Name: result_serializer

Overview:
Transmit-side counterpart of the grouper. Accepts wide result words from the DNN output path (for example a 64-bit actL_alln snapshot taken on each cycle_clk) into a small FIFO. It splits each word into bytes and hands them one at a time to the UART transmitter through a start/busy handshake. It runs in the UART (100 MHz) clock domain, alongside the grouper.

Parameters:
DATA_W, 64, width of one input word; must be a multiple of 8
DEPTH, 4, FIFO depth in words; must be a power of 2, at least 2
LSB_FIRST, 1, 1 sends data_in[7:0] first; 0 sends data_in[DATA_W-1:DATA_W-8] first

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
data_in  in  DATA_W  result word to send
w_en  in  1  write strobe; data_in is captured on a clk edge where w_en=1 and full=0
full  out  1  FIFO holds DEPTH words
empty  out  1  FIFO holds 0 words
tx_data  out  8  byte presented to the UART transmitter
tx_start  out  1  one-cycle request to transmit tx_data
tx_busy  in  1  UART transmitter is shifting a byte
idle  out  1  FIFO empty and FSM in IDLE
overflow  out  1  sticky: a write was attempted while full
sent_words  out  16  count of words fully transmitted; wraps modulo 2^16

Behaviour:
- Reset values while rst=1 (asynchronous):
  - FIFO pointers and count=0; full=0, empty=1, idle=1.
  - tx_data=0, tx_start=0, overflow=0, sent_words=0.
  - FSM=IDLE; shift register and byte_idx cleared.
- Reset mid-transfer:
  - The in-flight word and all queued words are discarded.
  - tx_start drops immediately.
  - No partial word is resumed after reset.
- FIFO:
  - Write when w_en && !full.
  - w_en && full: the word is dropped, overflow is set and held until rst, and FIFO contents are unchanged.
  - Pop is internal, issued by the FSM in IDLE.
  - Write and pop in the same cycle leave the count unchanged, including when count=DEPTH.
  - Pointers wrap modulo DEPTH.
  - full/empty are registered from the count.
- FSM states: IDLE, SEND, HOLD, WAIT.
  - IDLE, with empty=0: pop the head word into the shift register, byte_idx<=0, go to SEND.
  - SEND: tx_data holds the current byte.
    - If tx_busy=0: tx_start=1 for this cycle only, go to HOLD.
    - Otherwise stay in SEND with tx_start=0.
  - HOLD: one guard cycle, tx_start=0, always go to WAIT. This covers a transmitter that raises tx_busy one cycle after start.
  - WAIT: stay while tx_busy=1. On tx_busy=0:
    - If byte_idx = DATA_W/8-1: sent_words<=sent_words+1, go to IDLE.
    - Otherwise: byte_idx<=byte_idx+1, go to SEND.
- Byte selection:
  - LSB_FIRST=1: byte k = word[8k+7:8k].
  - LSB_FIRST=0: byte k = word[DATA_W-1-8k : DATA_W-8-8k].
- tx_data stability:
  - tx_data is registered and updates only on entry to SEND.
  - It is stable from SEND through the end of WAIT.
- Latency:
  - w_en at edge N into an empty FIFO gives empty=0 after N.
  - IDLE pops at edge N+1, so the FSM is in SEND during cycle N+1 to N+2.
  - First tx_start is in that cycle if tx_busy=0.
- Throughput: one byte per (transmitter busy time + 3) cycles minimum. The IDLE pop costs one extra cycle per word.
- idle = empty && FSM==IDLE; it deasserts the cycle after the first accepted write.
- tx_start is never asserted on two consecutive cycles.
- tx_start is never asserted while tx_busy=1.

Test Plan:
- Single word, DATA_W=64, LSB_FIRST=1:
  - Stimulus: data_in=64'h0807060504030201 with w_en one cycle; transmitter model busy for 10 cycles per byte.
  - Response: tx_data sequence 01,02,...,08; exactly 8 tx_start pulses; sent_words=1; idle=1 afterwards.
- LSB_FIRST=0, same word -> sequence 08,07,...,01.
- Overflow, with tx_busy held at 1:
  - Stimulus: write 6 words, DEPTH=4.
  - Response: the first word is popped into the shift register, so the FIFO accepts words 1-5 and full=1 after word 5; word 6 is dropped; overflow=1.
  - After releasing tx_busy: 5 words (40 bytes) are sent in order; sent_words=5; overflow stays 1.
- Simultaneous write and pop:
  - Stimulus: w_en asserted in the exact cycle the FSM pops from a FIFO with count=DEPTH.
  - Response: full stays 1 and no word is dropped (overflow=0).
- Reset mid-word:
  - Stimulus: assert rst asynchronously between clk edges after 3 bytes of word 64'hAABBCCDDEEFF1122 are sent.
  - Response: tx_start=0 and empty=1 immediately; sent_words=0.
  - After release, writing 64'h1 gives bytes 01,00,00,00,00,00,00,00.
- Busy-late transmitter (tx_busy rises 1 cycle after tx_start):
  - Response: no double tx_start, and each byte is sent exactly once.
